// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: baud arithmetic, frame
// length and the scheduler FSM encoding. The transmitter derives its bit
// period from the same baud_cnt_max() so frame timing stays in lock-step.
package uart_pkg;

  // Start bit, 8 data bits, stop bit, plus one bit period of margin.
  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_FRAME  = 2'd2,
    ST_GAP    = 2'd3
  } sched_state_e;

  // Clock cycles per UART bit period (integer division).
  function automatic int baud_cnt_max(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Width of a counter that must reach max_count-1; never narrower than 1 bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 2) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter. Scans requests starting at ptr and
// wrapping modulo NUM_REQ; the first asserted request wins. The pointer
// register lives in the caller.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GW      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      grant_idx,
  output logic               any
);

  int unsigned idx;

  // Priority scan from ptr upward with wrap; only the first hit is granted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NUM_REQ byte producers. A byte is
// accepted in IDLE via round-robin, launched with a one-cycle start strobe,
// and held on ser_to_para while the frame (and optional gap) is timed out
// locally, since the transmitter has no completion output.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int UART_BAUD_RATE = 9600,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int GAP_CYCLES     = 0,
  localparam int GW            = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rstn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 flag_begin,
  output logic [7:0]           ser_to_para,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BAUD_RATE);
  localparam int FRAME_CYCLES = FRAME_BITS * BAUD_CNT_MAX;
  localparam int CNT_MAX      = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW           = cnt_width(CNT_MAX);

  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] LAST_IDX   = GW'(NUM_REQ - 1);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gid_q, gid_d;
  logic [7:0]    data_q, data_d;
  logic          flag_q, flag_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [GW-1:0]      arb_idx;
  logic               arb_any;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Ready is offered only while idle; it is also masked while reset is held
  // so no requester sees a handshake that cannot complete.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && sys_rstn) begin
      req_ready = arb_grant;
    end
  end

  assign flag_begin  = flag_q;
  assign ser_to_para = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign grant_id    = gid_q;

  // Next-state logic: accept in IDLE, strobe in LAUNCH, time FRAME and GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    flag_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          data_d  = req_data[8*arb_idx +: 8];
          gid_d   = arb_idx;
          ptr_d   = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
          flag_d  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_FRAME;
      end
      ST_FRAME: begin
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; an asynchronous reset aborts any frame.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

endmodule
